open_drain_ctrl: RTL and testbench
==================================

OPEN_DRAIN_CTRL -- requirements
Module: open_drain_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, the number of open-drain wire-OR lines (RES, IRQ, NMI, ...).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the input synchronizer depth (at least 2).
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, the consecutive stable cycles required before level_o changes (at least 1).
REQ-004 SHALL have parameter MIN_ASSERT_CYCLES, default 8, the minimum cycles pin_n_oe stays high per assertion (at least 1).
REQ-005 SHALL have sys_clock_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have sys_reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have pin_n_i, input, CHANNELS bits: raw active-low wire state.
REQ-008 SHALL have pin_n_o, output, CHANNELS bits: driven value, constant 0.
REQ-009 SHALL have pin_n_oe, output, CHANNELS bits: per-line drive enable, active high.
REQ-010 SHALL have assert_i, input, CHANNELS bits: active-high request to pull the line low.
REQ-011 SHALL have level_o, output, CHANNELS bits: synchronized and filtered line state, active high (1 = line low).
REQ-012 SHALL have assert_edge_o and release_edge_o, outputs, CHANNELS bits each: one-cycle pulses on level_o 0->1 and 1->0.
REQ-013 SHALL have external_o, output, CHANNELS bits: line asserted by another device while this block is not driving it.

Function
REQ-014 SHALL hold pin_n_o at 0 permanently, so the line is driven only through pin_n_oe.
REQ-015 SHALL run one independent FSM per channel with states IDLE, DRIVE and STRETCH, and drive pin_n_oe = (state != IDLE) from a register.
REQ-016 SHALL, in IDLE with assert_i=1, go to DRIVE and load cnt=1, so pin_n_oe rises on the next cycle (latency 1).
REQ-017 SHALL, in DRIVE, increment cnt with saturation at MIN_ASSERT_CYCLES; on assert_i=0 go to IDLE if cnt >= MIN_ASSERT_CYCLES, otherwise go to STRETCH.
REQ-018 SHALL, in STRETCH, increment cnt and go to IDLE when cnt reaches MIN_ASSERT_CYCLES; assert_i=1 returns to DRIVE without resetting cnt.
REQ-019 SHALL size cnt as clog2(MIN_ASSERT_CYCLES+1) bits so it never wraps.
REQ-020 SHALL invert pin_n_i and pass it through SYNC_STAGES flops to form sync.
REQ-021 SHALL, with the filter built in, change level_o only after sync differs from level_o for FILTER_CYCLES consecutive cycles; any matching cycle clears the filter counter, and total latency is SYNC_STAGES+FILTER_CYCLES cycles.
REQ-022 SHALL register assert_edge_o and release_edge_o so each pulses in the same cycle level_o changes, and never both at once.
REQ-023 SHALL set external_o = level_o AND state==IDLE AND blank==0, where blank loads SYNC_STAGES+FILTER_CYCLES+1 when pin_n_oe falls and counts down to 0.
REQ-024 SHALL keep channels fully independent; simultaneous requests on all channels are legal.

Reset
REQ-025 SHALL, while sys_reset_ni=0, asynchronously force state=IDLE, pin_n_oe=0, synchronizer flops=0, level_o=0, edges=0, external_o=0 and all counters=0.
REQ-026 SHALL treat reset during DRIVE or STRETCH as abandoning the assertion: pin_n_oe drops immediately and there is no stretch after release.
REQ-027 SHALL generate no edge pulse in the first cycle after reset release.

Configuration
REQ-028 SHALL, when OPEN_DRAIN_FILTER_EN is defined, include the REQ-021 glitch filter.
REQ-029 SHALL, when OPEN_DRAIN_FILTER_EN is undefined, set level_o = sync registered once (latency SYNC_STAGES+1), ignore FILTER_CYCLES, and load blank with SYNC_STAGES+2.

Structure
REQ-030 SHALL place the state enum (IDLE, DRIVE, STRETCH) and default parameter constants in package open_drain_pkg.
REQ-031 SHALL implement per-line logic in sub-module open_drain_channel, instantiated CHANNELS times by a generate loop; open_drain_ctrl contains no other logic.

Verification (CHANNELS=3, SYNC_STAGES=2, FILTER_CYCLES=4, MIN_ASSERT_CYCLES=8)
REQ-032 SHALL cover: 1-cycle assert_i[0] pulse -> pin_n_oe[0] high for exactly 8 cycles starting 1 cycle later; pin_n_o stays 0.
REQ-033 SHALL cover: assert_i[1] held 20 cycles -> pin_n_oe[1] high 20 cycles and low 1 cycle after assert_i falls; re-assert during STRETCH extends without a gap.
REQ-034 SHALL cover (filter built in): pin_n_i[2] low for 3 cycles -> level_o[2] stays 0 with no edges; pin_n_i[2] low for 10 cycles -> level_o[2] rises 6 cycles after the fall with a single assert_edge_o[2] pulse, then release_edge_o[2] after the rise.
REQ-035 SHALL cover: pin_n_i[0] low with assert_i=0 -> external_o[0]=1 when level_o[0]=1; self-driven assertion -> external_o[0] stays 0 through the 7-cycle blank window.
REQ-036 SHALL cover: sys_reset_ni low mid-DRIVE -> pin_n_oe=0 and level_o=0 the same cycle; after release all channels are IDLE with no edge pulse.
REQ-037 SHALL cover (filter built out): 1-cycle pin_n_i[1] glitch -> level_o[1] pulses high for 1 cycle, 3 cycles later.

Source files
------------

// File: rtl/open_drain_pkg.sv
// open_drain_pkg: shared types and default parameter values for the
// open-drain wire-OR line controller.
package open_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        STRETCH = 2'd2
    } od_state_e;

    localparam int DEFAULT_CHANNELS          = 3;
    localparam int DEFAULT_SYNC_STAGES       = 2;
    localparam int DEFAULT_FILTER_CYCLES     = 4;
    localparam int DEFAULT_MIN_ASSERT_CYCLES = 8;

endpackage

// File: rtl/open_drain_channel.sv
// open_drain_channel: one open-drain line. It stretches every drive request
// to a minimum width, synchronizes and (optionally) glitch-filters the wire,
// and flags assertions made by other devices on the shared line.
// Build option: define OPEN_DRAIN_FILTER_EN to include the glitch filter;
// without it level_o is the synchronized wire registered once.
module open_drain_channel
    import open_drain_pkg::*;
#(
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int FILTER_CYCLES     = DEFAULT_FILTER_CYCLES,
    parameter int MIN_ASSERT_CYCLES = DEFAULT_MIN_ASSERT_CYCLES
) (
    input  logic sys_clock_i,
    input  logic sys_reset_ni,
    input  logic pin_n_i,
    output logic pin_n_o,
    output logic pin_n_oe,
    input  logic assert_i,
    output logic level_o,
    output logic assert_edge_o,
    output logic release_edge_o,
    output logic external_o
);

    localparam int CNT_W = $clog2(MIN_ASSERT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_ASSERT_CYCLES);

`ifdef OPEN_DRAIN_FILTER_EN
    localparam int BLANK_LOAD = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int FILT_W     = $clog2(FILTER_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
`else
    localparam int BLANK_LOAD = SYNC_STAGES + 2;
`endif

    localparam int BLANK_W = $clog2(BLANK_LOAD + 1);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(BLANK_LOAD);

    // Reject parameter values the logic below cannot honour.
    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || MIN_ASSERT_CYCLES < 1) begin : g_param_check
        $error("open_drain_channel: SYNC_STAGES>=2, FILTER_CYCLES>=1, MIN_ASSERT_CYCLES>=1 required");
    end

    od_state_e               state;
    od_state_e               state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [BLANK_W-1:0]      blank;
    logic [SYNC_STAGES-1:0]  sync_ff;
    logic                    sync;
    logic                    level_next;

    // The line is only ever pulled low; releasing it means tri-stating.
    assign pin_n_o = 1'b0;
    assign sync    = sync_ff[SYNC_STAGES-1];

    // FSM state and assertion-length counter.
    always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: cnt counts cycles the line has been driven, saturating at the minimum width.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (assert_i) begin
                    state_next = DRIVE;
                    cnt_next   = CNT_W'(1);
                end
            end
            DRIVE: begin
                if (!assert_i && cnt >= CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    if (!assert_i) begin
                        state_next = STRETCH;
                    end
                    if (cnt < CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            STRETCH: begin
                if (assert_i) begin
                    state_next = DRIVE;
                    if (cnt < CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                end else if (cnt >= CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered drive enable, plus a blanking window that hides our own release echo.
    always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            pin_n_oe <= 1'b0;
            blank    <= '0;
        end else begin
            pin_n_oe <= (state_next != IDLE);
            if (pin_n_oe && state_next == IDLE) begin
                blank <= BLANK_INIT;
            end else if (blank != '0) begin
                blank <= blank - 1'b1;
            end
        end
    end

    // Synchronizer chain on the inverted wire (1 = line pulled low).
    always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], ~pin_n_i};
        end
    end

`ifdef OPEN_DRAIN_FILTER_EN
    logic [FILT_W-1:0] filt_cnt;
    logic [FILT_W-1:0] filt_next;

    // Filter: the level follows sync only after it has disagreed for FILTER_CYCLES cycles in a row.
    always_comb begin
        level_next = level_o;
        filt_next  = '0;
        if (sync != level_o) begin
            if (filt_cnt == FILT_LAST) begin
                level_next = sync;
            end else begin
                filt_next = filt_cnt + 1'b1;
            end
        end
    end

    // Filter run-length counter.
    always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_next;
        end
    end
`else
    assign level_next = sync;
`endif

    // Level register and its edge pulses, all updated on the same clock.
    always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            level_o        <= 1'b0;
            assert_edge_o  <= 1'b0;
            release_edge_o <= 1'b0;
        end else begin
            level_o        <= level_next;
            assert_edge_o  <= level_next & ~level_o;
            release_edge_o <= ~level_next & level_o;
        end
    end

    assign external_o = level_o & (state == IDLE) & (blank == '0);

endmodule

// File: rtl/open_drain_ctrl.sv
// open_drain_ctrl: bank of independent open-drain line controllers
// (RES, IRQ, NMI, ...), one open_drain_channel per line.
// Build option: define OPEN_DRAIN_FILTER_EN to include the per-line glitch filter.
module open_drain_ctrl
    import open_drain_pkg::*;
#(
    parameter int CHANNELS          = DEFAULT_CHANNELS,
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int FILTER_CYCLES     = DEFAULT_FILTER_CYCLES,
    parameter int MIN_ASSERT_CYCLES = DEFAULT_MIN_ASSERT_CYCLES
) (
    input  logic                sys_clock_i,
    input  logic                sys_reset_ni,
    input  logic [CHANNELS-1:0] pin_n_i,
    output logic [CHANNELS-1:0] pin_n_o,
    output logic [CHANNELS-1:0] pin_n_oe,
    input  logic [CHANNELS-1:0] assert_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] assert_edge_o,
    output logic [CHANNELS-1:0] release_edge_o,
    output logic [CHANNELS-1:0] external_o
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        open_drain_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .FILTER_CYCLES    (FILTER_CYCLES),
            .MIN_ASSERT_CYCLES(MIN_ASSERT_CYCLES)
        ) u_channel (
            .sys_clock_i   (sys_clock_i),
            .sys_reset_ni  (sys_reset_ni),
            .pin_n_i       (pin_n_i[ch]),
            .pin_n_o       (pin_n_o[ch]),
            .pin_n_oe      (pin_n_oe[ch]),
            .assert_i      (assert_i[ch]),
            .level_o       (level_o[ch]),
            .assert_edge_o (assert_edge_o[ch]),
            .release_edge_o(release_edge_o[ch]),
            .external_o    (external_o[ch])
        );
    end

endmodule

// File: tb/tb_open_drain_ctrl.sv
// tb_open_drain_ctrl: self-checking bench for open_drain_ctrl. A behavioural
// model (pulse stretcher, sample history, blanking timer) runs in lockstep
// with the DUT. Works with or without OPEN_DRAIN_FILTER_EN.
module tb_open_drain_ctrl;

    localparam int CH = 3;
    localparam int S  = 2;
    localparam int F  = 4;
    localparam int M  = 8;
    localparam int HL = S + F;
`ifdef OPEN_DRAIN_FILTER_EN
    localparam int BLANK_LEN = S + F + 1;
    localparam int LEVEL_LAT = S + F;
`else
    localparam int BLANK_LEN = S + 2;
    localparam int LEVEL_LAT = S + 1;
`endif

    logic          sys_clock_i = 1'b0;
    logic          sys_reset_ni;
    logic [CH-1:0] pin_n_i;
    logic [CH-1:0] assert_i;
    logic [CH-1:0] pin_n_o;
    logic [CH-1:0] pin_n_oe;
    logic [CH-1:0] level_o;
    logic [CH-1:0] assert_edge_o;
    logic [CH-1:0] release_edge_o;
    logic [CH-1:0] external_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_oe    [CH];
    int m_run   [CH];
    int m_since [CH];
    bit m_level [CH];
    bit m_ae    [CH];
    bit m_re    [CH];
    bit hist    [CH][HL];

    open_drain_ctrl #(
        .CHANNELS         (CH),
        .SYNC_STAGES      (S),
        .FILTER_CYCLES    (F),
        .MIN_ASSERT_CYCLES(M)
    ) dut (
        .sys_clock_i   (sys_clock_i),
        .sys_reset_ni  (sys_reset_ni),
        .pin_n_i       (pin_n_i),
        .pin_n_o       (pin_n_o),
        .pin_n_oe      (pin_n_oe),
        .assert_i      (assert_i),
        .level_o       (level_o),
        .assert_edge_o (assert_edge_o),
        .release_edge_o(release_edge_o),
        .external_o    (external_o)
    );

    always #5 sys_clock_i = ~sys_clock_i;

    function automatic logic [CH-1:0] exp_oe();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_oe[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_level();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_level[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_ae();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_ae[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_re();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_re[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_ext();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_level[c] && !m_oe[c] && (m_since[c] >= BLANK_LEN);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_oe[c]    = 1'b0;
            m_run[c]   = 0;
            m_since[c] = 1000;
            m_level[c] = 1'b0;
            m_ae[c]    = 1'b0;
            m_re[c]    = 1'b0;
            for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs as they are now.
    task automatic model_edge();
        bit raw, new_oe, new_level, all_diff;
        for (int c = 0; c < CH; c++) begin
            raw = !pin_n_i[c];
            // drive enable: follows the request, held until at least M cycles high
            new_oe = assert_i[c] || (m_oe[c] && m_run[c] < M);
            if (m_oe[c] && !new_oe) m_since[c] = 0;
            else if (m_since[c] < 1000) m_since[c]++;
            m_run[c] = new_oe ? (m_oe[c] ? m_run[c] + 1 : 1) : 0;
            m_oe[c]  = new_oe;
            // level: hist[c][HL-j] holds the wire sample taken j edges ago
`ifdef OPEN_DRAIN_FILTER_EN
            all_diff = 1'b1;
            for (int k = 0; k < F; k++) if (hist[c][HL-S-k] == m_level[c]) all_diff = 1'b0;
            new_level = all_diff ? !m_level[c] : m_level[c];
`else
            all_diff  = 1'b0;
            new_level = hist[c][HL-S] | all_diff;
`endif
            m_ae[c]    = new_level && !m_level[c];
            m_re[c]    = !new_level && m_level[c];
            m_level[c] = new_level;
            for (int k = 0; k < HL - 1; k++) hist[c][k] = hist[c][k+1];
            hist[c][HL-1] = raw;
        end
    endtask

    task automatic tick();
        @(posedge sys_clock_i);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        sys_reset_ni = 1'b0;
        pin_n_i      = 3'b101;
        assert_i     = '0;
        model_reset();
        repeat (3) @(posedge sys_clock_i);
        #1;
        checks++;
        if ({pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got oe=%b lvl=%b ae=%b re=%b ext=%b, expected all zero",
                     pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o);
        end
        checks++;
        if (pin_n_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_pin_n_o: got %b expected 000", pin_n_o);
        end
        @(negedge sys_clock_i);
        sys_reset_ni = 1'b1;
        for (int i = 0; i < 12 + LEVEL_LAT; i++) begin
            tick();
            if (i == 12) pin_n_i = '1;
            if (i == 0) begin
                checks++;
                if ({assert_edge_o, release_edge_o} !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_first_edges: got ae=%b re=%b expected 000 000", assert_edge_o, release_edge_o);
                end
            end
            checks++;
            if ({pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o} !==
                {exp_oe(), exp_level(), exp_ae(), exp_re(), exp_ext()}) begin
                errors++;
                $display("[TB] FAIL reset_release cycle %0d: got oe=%b lvl=%b ae=%b re=%b ext=%b expected oe=%b lvl=%b ae=%b re=%b ext=%b",
                         i, pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o,
                         exp_oe(), exp_level(), exp_ae(), exp_re(), exp_ext());
            end
        end
        repeat (LEVEL_LAT + 2) tick();
    endtask

    task automatic test_pulse_stretch();
        int highs = 0;
        int first = -1;
        $display("[TB] test_pulse_stretch");
        assert_i[0] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            assert_i[0] = 1'b0;
            if (pin_n_oe[0]) begin
                highs++;
                if (first < 0) first = i;
            end
            checks++;
            if (pin_n_oe !== exp_oe() || pin_n_o !== '0) begin
                errors++;
                $display("[TB] FAIL pulse_oe cycle %0d: got oe=%b pin_n_o=%b expected oe=%b pin_n_o=000", i, pin_n_oe, pin_n_o, exp_oe());
            end
        end
        checks++;
        if (highs !== M || first !== 0) begin
            errors++;
            $display("[TB] FAIL pulse_width: got %0d cycles starting at %0d, expected %0d starting at 0", highs, first, M);
        end
    endtask

    task automatic test_hold_reextend();
        int highs = 0;
        int gap   = 0;
        bit fell  = 1'b0;
        $display("[TB] test_hold_reextend");
        assert_i[1] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 19) assert_i[1] = 1'b0;
            if (pin_n_oe[1]) highs++;
            checks++;
            if (pin_n_oe !== exp_oe()) begin
                errors++;
                $display("[TB] FAIL hold_oe cycle %0d: got %b expected %b", i, pin_n_oe, exp_oe());
            end
        end
        checks++;
        if (highs !== 20) begin
            errors++;
            $display("[TB] FAIL hold_width: got %0d cycles expected 20", highs);
        end
        highs = 0;
        assert_i[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 13) assert_i[1] = 1'b0;
            if (i == 3) assert_i[1] = 1'b1;
            if (pin_n_oe[1]) begin
                highs++;
                if (fell) gap++;
            end else begin
                fell = 1'b1;
            end
            checks++;
            if (pin_n_oe !== exp_oe()) begin
                errors++;
                $display("[TB] FAIL reextend_oe cycle %0d: got %b expected %b", i, pin_n_oe, exp_oe());
            end
        end
        checks++;
        if (highs !== 14 || gap !== 0) begin
            errors++;
            $display("[TB] FAIL reextend_width: got %0d cycles gap %0d expected 14 cycles gap 0", highs, gap);
        end
    endtask

    task automatic test_glitch();
        int ae_n = 0, re_n = 0, lvl_n = 0, rise = -1, fall = -1;
        $display("[TB] test_glitch");
`ifdef OPEN_DRAIN_FILTER_EN
        pin_n_i[2] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 2) pin_n_i[2] = 1'b1;
            lvl_n += int'(level_o[2]) + int'(assert_edge_o[2]) + int'(release_edge_o[2]);
            checks++;
            if ({level_o, assert_edge_o, release_edge_o} !== {exp_level(), exp_ae(), exp_re()}) begin
                errors++;
                $display("[TB] FAIL short_glitch cycle %0d: got lvl=%b ae=%b re=%b expected lvl=%b ae=%b re=%b",
                         i, level_o, assert_edge_o, release_edge_o, exp_level(), exp_ae(), exp_re());
            end
        end
        checks++;
        if (lvl_n !== 0) begin
            errors++;
            $display("[TB] FAIL short_glitch_quiet: got %0d active level/edge cycles expected 0", lvl_n);
        end
        pin_n_i[2] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 9) pin_n_i[2] = 1'b1;
            if (assert_edge_o[2]) begin ae_n++; rise = i; end
            if (release_edge_o[2]) begin re_n++; fall = i; end
            checks++;
            if ({level_o, assert_edge_o, release_edge_o} !== {exp_level(), exp_ae(), exp_re()}) begin
                errors++;
                $display("[TB] FAIL long_low cycle %0d: got lvl=%b ae=%b re=%b expected lvl=%b ae=%b re=%b",
                         i, level_o, assert_edge_o, release_edge_o, exp_level(), exp_ae(), exp_re());
            end
        end
        checks++;
        if (ae_n !== 1 || re_n !== 1 || rise !== LEVEL_LAT - 1 || fall !== 10 + LEVEL_LAT - 1) begin
            errors++;
            $display("[TB] FAIL long_low_edges: got ae=%0d@%0d re=%0d@%0d expected 1@%0d 1@%0d",
                     ae_n, rise, re_n, fall, LEVEL_LAT - 1, 10 + LEVEL_LAT - 1);
        end
`else
        pin_n_i[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pin_n_i[1] = 1'b1;
            if (level_o[1]) begin lvl_n++; if (rise < 0) rise = i; end
            if (assert_edge_o[1]) ae_n++;
            if (release_edge_o[1]) re_n++;
            checks++;
            if ({level_o, assert_edge_o, release_edge_o} !== {exp_level(), exp_ae(), exp_re()}) begin
                errors++;
                $display("[TB] FAIL glitch cycle %0d: got lvl=%b ae=%b re=%b expected lvl=%b ae=%b re=%b",
                         i, level_o, assert_edge_o, release_edge_o, exp_level(), exp_ae(), exp_re());
            end
        end
        checks++;
        if (lvl_n !== 1 || rise !== LEVEL_LAT - 1 || ae_n !== 1 || re_n !== 1) begin
            errors++;
            $display("[TB] FAIL glitch_pulse: got width %0d at %0d ae=%0d re=%0d expected width 1 at %0d ae=1 re=1",
                     lvl_n, rise, ae_n, re_n, LEVEL_LAT - 1);
        end
`endif
    endtask

    task automatic test_external();
        bit saw_level = 1'b0;
        $display("[TB] test_external");
        pin_n_i[0] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 11) begin
                checks++;
                if (external_o[0] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL external_seen: got %b expected 1", external_o[0]);
                end
                pin_n_i[0] = 1'b1;
            end
            checks++;
            if ({level_o, external_o} !== {exp_level(), exp_ext()}) begin
                errors++;
                $display("[TB] FAIL external_other cycle %0d: got lvl=%b ext=%b expected lvl=%b ext=%b",
                         i, level_o, external_o, exp_level(), exp_ext());
            end
        end
        assert_i[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            assert_i[0] = 1'b0;
            pin_n_i[0]  = !m_oe[0];
            saw_level   = saw_level | level_o[0];
            checks++;
            if (external_o[0] !== 1'b0 || {level_o, external_o} !== {exp_level(), exp_ext()}) begin
                errors++;
                $display("[TB] FAIL external_self cycle %0d: got lvl=%b ext=%b expected lvl=%b ext=%b",
                         i, level_o, external_o, exp_level(), exp_ext());
            end
        end
        checks++;
        if (saw_level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL external_self_level: level_o[0] never rose, expected 1");
        end
    endtask

    task automatic test_reset_mid_drive();
        $display("[TB] test_reset_mid_drive");
        assert_i = '1;
        for (int i = 0; i < 10; i++) begin
            tick();
            pin_n_i = ~exp_oe();
        end
        checks++;
        if (pin_n_oe !== '1 || level_o !== '1) begin
            errors++;
            $display("[TB] FAIL pre_reset: got oe=%b lvl=%b expected oe=111 lvl=111", pin_n_oe, level_o);
        end
        #2;
        sys_reset_ni = 1'b0;
        #1;
        checks++;
        if ({pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got oe=%b lvl=%b ae=%b re=%b ext=%b expected all zero",
                     pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o);
        end
        model_reset();
        assert_i = '0;
        pin_n_i  = '1;
        @(negedge sys_clock_i);
        sys_reset_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o} !==
                {exp_oe(), exp_level(), exp_ae(), exp_re(), exp_ext()} ||
                (i == 0 && {pin_n_oe, assert_edge_o, release_edge_o} !== '0)) begin
                errors++;
                $display("[TB] FAIL after_reset cycle %0d: got oe=%b lvl=%b ae=%b re=%b ext=%b expected oe=%b lvl=%b ae=%b re=%b ext=%b",
                         i, pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o,
                         exp_oe(), exp_level(), exp_ae(), exp_re(), exp_ext());
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] ext_low = '0;
        $display("[TB] test_random");
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) ext_low[c] = ~ext_low[c];
                if ($urandom_range(0, 5) == 0) assert_i[c] = ~assert_i[c];
                pin_n_i[c] = !(ext_low[c] || m_oe[c]);
            end
            tick();
            checks++;
            if ({pin_n_o, pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o} !==
                {3'b000, exp_oe(), exp_level(), exp_ae(), exp_re(), exp_ext()}) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got o=%b oe=%b lvl=%b ae=%b re=%b ext=%b expected o=000 oe=%b lvl=%b ae=%b re=%b ext=%b",
                         i, pin_n_o, pin_n_oe, level_o, assert_edge_o, release_edge_o, external_o,
                         exp_oe(), exp_level(), exp_ae(), exp_re(), exp_ext());
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse_stretch();
        test_hold_reextend();
        test_glitch();
        test_external();
        test_reset_mid_drive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
